// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared core types for the integer register file
package hsv_core_pkg;
  localparam int WORD_W = 32;
  localparam int REG_COUNT = 32;
  typedef logic [WORD_W-1:0] word;
  typedef logic [$clog2(REG_COUNT)-1:0] reg_addr;
  localparam reg_addr REG_ZERO = '0;
endpackage

// File: rtl/hsv_core_regfile_scoreboard.sv
// hsv_core_regfile_scoreboard: per-register busy bits, set on issue, cleared by flush or writeback
module hsv_core_regfile_scoreboard
  import hsv_core_pkg::*;
#(
  parameter int NUM_WRITE = 2,
  parameter int NUM_REGS = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                           clk_core,
  input  logic                           rst_n,
  input  logic                           issue_en,
  input  logic [AW-1:0]                  issue_addr,
  input  logic                           flush,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE-1:0][AW-1:0]   wr_addr,
  output logic [NUM_REGS-1:0]            busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d, wr_hit;
  always_comb begin
    wr_hit = '0;
    for (int w = 0; w < NUM_WRITE; w++)
      if (wr_en[w]) wr_hit[wr_addr[w]] = 1'b1;
    // issue beats flush beats writeback: the newest instruction owns the register
    for (int r = 0; r < NUM_REGS; r++)
      busy_d[r] = (issue_en && issue_addr == AW'(r)) ? 1'b1 :
                  (flush || wr_hit[r])               ? 1'b0 : busy_q[r];
    busy_d[AW'(REG_ZERO)] = 1'b0;
  end
  always_ff @(posedge clk_core)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_o = busy_q;
endmodule

// File: rtl/hsv_core_regfile_mp.sv
// hsv_core_regfile_mp: multi-port integer register file with busy scoreboard and optional write bypass
module hsv_core_regfile_mp
  import hsv_core_pkg::*;
#(
  parameter int NUM_READ = 2,
  parameter int NUM_WRITE = 2,
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                           clk_core,
  input  logic                           rst_n,
  input  logic [NUM_READ-1:0][AW-1:0]    rd_addr,
  output logic [NUM_READ-1:0][XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE-1:0][AW-1:0]   wr_addr,
  input  logic [NUM_WRITE-1:0][XLEN-1:0] wr_data,
  input  logic                           issue_en,
  input  logic [AW-1:0]                  issue_addr,
  input  logic                           flush,
  output logic                           any_busy
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  hsv_core_regfile_scoreboard #(.NUM_WRITE(NUM_WRITE), .NUM_REGS(NUM_REGS)) u_sb (
    .clk_core  (clk_core),
    .rst_n     (rst_n),
    .issue_en  (issue_en),
    .issue_addr(issue_addr),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy_o    (busy)
  );
  // later ports overwrite earlier ones, so the highest index wins
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NUM_WRITE; w++)
      if (wr_en[w] && wr_addr[w] != ZERO) regs_d[wr_addr[w]] = wr_data[w];
  end
  always_ff @(posedge clk_core)
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data[i] = regs_q[rd_addr[i]];
      rd_busy[i] = busy[rd_addr[i]];
      for (int w = 0; w < NUM_WRITE; w++)
        if (BYPASS && wr_en[w] && wr_addr[w] == rd_addr[i] && rd_addr[i] != ZERO)
          rd_data[i] = wr_data[w];
    end
  end
  assign any_busy = |busy;
endmodule

// File: tb/tb_hsv_core_regfile_mp.sv
// tb_hsv_core_regfile_mp: directed scoreboard bench driving a bypassing and a non-bypassing instance
module tb_hsv_core_regfile_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4:0] rd_addr;
  logic [1:0][31:0] rd_data, rd_data_nb;
  logic [1:0] rd_busy, rd_busy_nb;
  logic [1:0] wr_en;
  logic [1:0][4:0] wr_addr;
  logic [1:0][31:0] wr_data;
  logic issue_en, flush, any_busy, any_busy_nb;
  logic [4:0] issue_addr;
  always #5 clk = ~clk;
  hsv_core_regfile_mp #(.BYPASS(1'b1)) dut (
    .clk_core(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .any_busy(any_busy)
  );
  hsv_core_regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk_core(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .flush(flush), .any_busy(any_busy_nb)
  );
  typedef struct {string tag; int kind; int idx; logic [31:0] exp;} chk_t;
  chk_t q[$];
  int passed = 0;
  int total = 0;
  task automatic push(string tag, int kind, int idx, logic [31:0] e);
    q.push_back('{tag, kind, idx, e});
  endtask
  function automatic logic [31:0] obs(int kind, int idx);
    case (kind)
      0: return rd_data[idx];
      1: return rd_data_nb[idx];
      2: return {31'b0, rd_busy[idx]};
      3: return {31'b0, rd_busy_nb[idx]};
      4: return {31'b0, any_busy};
      default: return {31'b0, any_busy_nb};
    endcase
  endfunction
  task automatic exp_data(string tag, int idx, logic [31:0] byp, logic [31:0] nb);
    push(tag, 0, idx, byp);
    push({tag, "_nb"}, 1, idx, nb);
  endtask
  task automatic exp_busy(string tag, int idx, logic b);
    push(tag, 2, idx, {31'b0, b});
    push({tag, "_nb"}, 3, idx, {31'b0, b});
  endtask
  task automatic exp_any(string tag, logic b);
    push(tag, 4, 0, {31'b0, b});
    push({tag, "_nb"}, 5, 0, {31'b0, b});
  endtask
  task automatic step();
    @(negedge clk);
    while (q.size() > 0) begin
      chk_t c = q.pop_front();
      logic [31:0] o = obs(c.kind, c.idx);
      total++;
      assert (o === c.exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", c.tag, o, c.exp);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wr_en = '0;
    issue_en = 1'b0;
    flush = 1'b0;
  endtask
  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p] = a;
    wr_data[p] = d;
  endtask
  task automatic iss(logic [4:0] a);
    issue_en = 1'b1;
    issue_addr = a;
  endtask
  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    issue_addr = '0;
    idle();
    @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a += 2) begin
      rd_addr[0] = 5'(a);
      rd_addr[1] = 5'(a + 1);
      exp_data("rst_data0", 0, 0, 0);
      exp_data("rst_data1", 1, 0, 0);
      exp_busy("rst_busy0", 0, 1'b0);
      exp_busy("rst_busy1", 1, 1'b0);
      exp_any("rst_any", 1'b0);
      step();
    end
    wr(0, 5'd3, 32'hDEADBEEF);
    wr(1, 5'd15, 32'hCAFEBABE);
    rd_addr[0] = 5'd3;
    rd_addr[1] = 5'd15;
    exp_data("byp_x3", 0, 32'hDEADBEEF, 32'h0);
    exp_data("byp_x15", 1, 32'hCAFEBABE, 32'h0);
    step();
    idle();
    exp_data("stored_x3", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    exp_data("stored_x15", 1, 32'hCAFEBABE, 32'hCAFEBABE);
    exp_busy("wr_nonbusy_x3", 0, 1'b0);
    step();
    wr(0, 5'd7, 32'h11111111);
    wr(1, 5'd7, 32'h22222222);
    rd_addr[0] = 5'd7;
    exp_data("prio_byp_x7", 0, 32'h22222222, 32'hDEADBEEF - 32'hDEADBEEF);
    step();
    idle();
    exp_data("prio_x7", 0, 32'h22222222, 32'h22222222);
    step();
    wr(0, 5'd0, 32'hFFFFFFFF);
    iss(5'd0);
    rd_addr[0] = 5'd0;
    rd_addr[1] = 5'd0;
    exp_data("x0_byp", 0, 0, 0);
    exp_busy("x0_busy_now", 0, 1'b0);
    step();
    idle();
    exp_data("x0_after", 1, 0, 0);
    exp_busy("x0_busy", 1, 1'b0);
    exp_any("x0_any", 1'b0);
    step();
    iss(5'd5);
    rd_addr[0] = 5'd5;
    exp_busy("x5_c1", 0, 1'b0);
    step();
    idle();
    exp_busy("x5_c2", 0, 1'b1);
    exp_any("x5_any_c2", 1'b1);
    step();
    step();
    wr(0, 5'd5, 32'hA5A5A5A5);
    iss(5'd5);
    exp_busy("x5_c4", 0, 1'b1);
    exp_data("x5_byp_c4", 0, 32'hA5A5A5A5, 32'h0);
    step();
    idle();
    exp_busy("x5_wr_iss_c5", 0, 1'b1);
    exp_data("x5_c5", 0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step();
    wr(1, 5'd5, 32'h5A5A5A5A);
    exp_busy("x5_c6", 0, 1'b1);
    step();
    idle();
    exp_busy("x5_cleared_c7", 0, 1'b0);
    exp_any("x5_any_c7", 1'b0);
    exp_data("x5_c7", 0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    step();
    iss(5'd9);
    step();
    iss(5'd10);
    rd_addr[0] = 5'd9;
    exp_busy("x9_busy", 0, 1'b1);
    step();
    iss(5'd12);
    flush = 1'b1;
    rd_addr[1] = 5'd10;
    exp_busy("x10_busy", 1, 1'b1);
    step();
    idle();
    rd_addr[0] = 5'd12;
    rd_addr[1] = 5'd9;
    exp_busy("flush_x12", 0, 1'b1);
    exp_busy("flush_x9", 1, 1'b0);
    exp_any("flush_any", 1'b1);
    step();
    rd_addr[1] = 5'd10;
    exp_busy("flush_x10", 1, 1'b0);
    step();
    rst_n = 1'b0;
    wr(0, 5'd3, 32'h12345678);
    wr(1, 5'd7, 32'h87654321);
    iss(5'd20);
    step();
    rst_n = 1'b1;
    idle();
    rd_addr[0] = 5'd3;
    rd_addr[1] = 5'd7;
    exp_data("rst2_x3", 0, 0, 0);
    exp_data("rst2_x7", 1, 0, 0);
    exp_any("rst2_any", 1'b0);
    step();
    rd_addr[0] = 5'd12;
    rd_addr[1] = 5'd20;
    exp_busy("rst2_x12", 0, 1'b0);
    exp_busy("rst2_x20", 1, 1'b0);
    exp_data("rst2_x20d", 1, 0, 0);
    step();
    rd_addr[0] = 5'd15;
    rd_addr[1] = 5'd5;
    exp_data("rst2_x15", 0, 0, 0);
    exp_data("rst2_x5", 1, 0, 0);
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
